// File: rtl/am_mod_pkg.sv
// rtl/am_mod_pkg.sv - shared types, constants and helpers for the AM modulator
package am_mod_pkg;

  localparam int LUT_DEPTH   = 256;
  localparam int CARRIER_AMP = 1024;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quadrant_t;

  function automatic int clamp_env(input int value, input int max_val);
    if (value < 0) begin
      return 0;
    end
    if (value > max_val) begin
      return max_val;
    end
    return value;
  endfunction

  // Odd quadrants read the quarter wave backwards, the lower half-cycle is negated.
  function automatic logic q_mirrored(input quadrant_t q);
    return (q == Q1) || (q == Q3);
  endfunction

  function automatic logic q_negated(input quadrant_t q);
    return (q == Q2) || (q == Q3);
  endfunction

endpackage

// File: rtl/am_sine_lut.sv
// rtl/am_sine_lut.sv - quarter-wave sine/cosine ROM with quadrant folding (stages S1-S2)
module am_sine_lut
  import am_mod_pkg::*;
#(
  parameter int DATA_WIDTH     = $clog2(CARRIER_AMP) + 2,
  parameter int LUT_ADDR_WIDTH = $clog2(LUT_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [LUT_ADDR_WIDTH+1:0]    phase,
  output logic signed [DATA_WIDTH-1:0] sin_out,
  output logic signed [DATA_WIDTH-1:0] cos_out
);

  localparam int  DEPTH   = 2 ** LUT_ADDR_WIDTH;
  localparam int  MAG_W   = DATA_WIDTH - 1;
  localparam real PEAK    = real'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam real HALF_PI = 1.5707963267948966;

  logic [MAG_W-1:0] rom [DEPTH];

  // Table contents are fixed at elaboration so the ROM maps to constants.
  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int VAL = $rtoi(PEAK * $sin(HALF_PI * real'(k) / real'(DEPTH)) + 0.5);
    assign rom[k] = MAG_W'(VAL);
  end

  quadrant_t                 sin_q;
  quadrant_t                 cos_q;
  logic [LUT_ADDR_WIDTH-1:0] addr_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_q  <= Q0;
      cos_q  <= Q0;
      addr_r <= '0;
    end else if (enable) begin
      sin_q  <= quadrant_t'(phase[LUT_ADDR_WIDTH+1:LUT_ADDR_WIDTH]);
      cos_q  <= quadrant_t'(phase[LUT_ADDR_WIDTH+1:LUT_ADDR_WIDTH] + 2'd1);
      addr_r <= phase[LUT_ADDR_WIDTH-1:0];
    end
  end

  logic [LUT_ADDR_WIDTH-1:0]   sin_idx;
  logic [LUT_ADDR_WIDTH-1:0]   cos_idx;
  logic signed [DATA_WIDTH-1:0] sin_mag;
  logic signed [DATA_WIDTH-1:0] cos_mag;
  logic signed [DATA_WIDTH-1:0] sin_next;
  logic signed [DATA_WIDTH-1:0] cos_next;

  always_comb begin
    sin_idx  = q_mirrored(sin_q) ? ~addr_r : addr_r;
    cos_idx  = q_mirrored(cos_q) ? ~addr_r : addr_r;
    sin_mag  = $signed({1'b0, rom[sin_idx]});
    cos_mag  = $signed({1'b0, rom[cos_idx]});
    sin_next = q_negated(sin_q) ? -sin_mag : sin_mag;
    cos_next = q_negated(cos_q) ? -cos_mag : cos_mag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sin_out <= '0;
      cos_out <= '0;
    end else if (enable) begin
      sin_out <= sin_next;
      cos_out <= cos_next;
    end
  end

endmodule

// File: rtl/am_modulator.sv
// rtl/am_modulator.sv - AM modulator: NCO, envelope hold, I/Q mixing and valid tracking
module am_modulator
  import am_mod_pkg::*;
#(
  parameter int DATA_WIDTH     = $clog2(CARRIER_AMP) + 2,
  parameter int PHASE_WIDTH    = 24,
  parameter int LUT_ADDR_WIDTH = $clog2(LUT_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [PHASE_WIDTH-1:0]       phase_inc,
  input  logic [8:0]                   mod_depth,
  input  logic signed [DATA_WIDTH-1:0] audio_in,
  input  logic                         audio_valid,
  output logic signed [DATA_WIDTH-1:0] inphase,
  output logic signed [DATA_WIDTH-1:0] quadrature,
  output logic                         out_valid
);

  localparam int AMP     = 2 ** (DATA_WIDTH - 2);
  localparam int ENV_MAX = (2 ** (DATA_WIDTH - 1)) - 1;
  localparam int PROD_W  = DATA_WIDTH + 10;
  localparam int MIX_W   = 2 * DATA_WIDTH;

  logic [PHASE_WIDTH-1:0]       phase_acc;
  logic [DATA_WIDTH-1:0]        env_reg;
  logic signed [PROD_W-1:0]     audio_prod;
  logic signed [PROD_W-1:0]     env_raw;
  logic signed [DATA_WIDTH-1:0] sin_s;
  logic signed [DATA_WIDTH-1:0] cos_s;
  logic signed [MIX_W-1:0]      i_mix;
  logic signed [MIX_W-1:0]      q_mix;
  logic [2:0]                   valid_sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_acc <= '0;
    end else if (enable) begin
      phase_acc <= phase_acc + phase_inc;
    end
  end

  always_comb begin
    audio_prod = PROD_W'(audio_in) * PROD_W'($signed({1'b0, mod_depth}));
    env_raw    = PROD_W'(AMP) + (audio_prod >>> 9);
  end

  // Envelope follows the audio strobe, independent of the carrier enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_reg <= '0;
    end else if (audio_valid) begin
      env_reg <= DATA_WIDTH'(clamp_env(int'(env_raw), ENV_MAX));
    end
  end

  am_sine_lut #(
    .DATA_WIDTH    (DATA_WIDTH),
    .LUT_ADDR_WIDTH(LUT_ADDR_WIDTH)
  ) u_sine_lut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .phase  (phase_acc[PHASE_WIDTH-1 -: LUT_ADDR_WIDTH+2]),
    .sin_out(sin_s),
    .cos_out(cos_s)
  );

  always_comb begin
    i_mix = MIX_W'($signed({1'b0, env_reg})) * MIX_W'(cos_s);
    q_mix = MIX_W'($signed({1'b0, env_reg})) * MIX_W'(sin_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inphase    <= '0;
      quadrature <= '0;
    end else if (enable) begin
      inphase    <= i_mix[DATA_WIDTH-1 +: DATA_WIDTH];
      quadrature <= q_mix[DATA_WIDTH-1 +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_sr <= '0;
    end else begin
      valid_sr <= {valid_sr[1:0], enable};
    end
  end

  assign out_valid = valid_sr[2];

endmodule
